// File: rtl/clint_pkg.sv
// Shared definitions for the CLINT timer: register offsets and the address decode result.
package clint_pkg;

    localparam logic [15:0] MSIP_BASE     = 16'h0000;
    localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
    localparam logic [15:0] MTIME_LO      = 16'hBFF8;
    localparam logic [15:0] MTIME_HI      = 16'hBFFC;
    localparam logic [15:0] ALIAS_BASE    = 16'hC000;

    // Wide enough for the largest legal hart count (16).
    localparam int HART_IDX_W = 4;

    typedef enum logic [2:0] {
        DEC_MSIP,
        DEC_CMP_LO,
        DEC_CMP_HI,
        DEC_MTIME_LO,
        DEC_MTIME_HI,
        DEC_ERR
    } dec_e;

endpackage

// File: rtl/clint_addr_decode.sv
// Combinational APB address (and requesting hart) decode for the CLINT register map.
// CLINT_HART_ALIAS_EN adds the hart-local window at 0xC000 addressed through phartid.
module clint_addr_decode
    import clint_pkg::*;
#(
    parameter int N_HARTS = 2,
    parameter int W_PADDR = 16
) (
    input  logic [W_PADDR-1:0]    paddr,
    input  logic [31:0]           phartid,
    output dec_e                  dec_kind,
    output logic [HART_IDX_W-1:0] dec_hart
);

    localparam logic [31:0] N_HARTS_U = 32'(N_HARTS);

    logic [31:0] addr;
    logic        unused_bits;

    assign addr = 32'(paddr);

`ifdef CLINT_HART_ALIAS_EN
    assign unused_bits = ^addr[1:0];
`else
    assign unused_bits = ^{addr[1:0], phartid};
`endif

    // Out-of-range harts fall through to DEC_ERR just like unmapped offsets.
    always_comb begin
        dec_kind = DEC_ERR;
        dec_hart = '0;
        if (addr[31:16] == 16'h0000) begin
            if (addr[15:6] == MSIP_BASE[15:6] && {28'h0, addr[5:2]} < N_HARTS_U) begin
                dec_kind = DEC_MSIP;
                dec_hart = addr[5:2];
            end else if (addr[15:7] == MTIMECMP_BASE[15:7] && {28'h0, addr[6:3]} < N_HARTS_U) begin
                dec_kind = addr[2] ? DEC_CMP_HI : DEC_CMP_LO;
                dec_hart = addr[6:3];
            end else if (addr[15:2] == MTIME_LO[15:2]) begin
                dec_kind = DEC_MTIME_LO;
            end else if (addr[15:2] == MTIME_HI[15:2]) begin
                dec_kind = DEC_MTIME_HI;
            end
`ifdef CLINT_HART_ALIAS_EN
            else if (addr[15:4] == ALIAS_BASE[15:4] && phartid < N_HARTS_U) begin
                dec_hart = phartid[HART_IDX_W-1:0];
                if (addr[3:2] == 2'b00) begin
                    dec_kind = DEC_MSIP;
                end else if (addr[3:2] == 2'b10) begin
                    dec_kind = DEC_CMP_LO;
                end else if (addr[3:2] == 2'b11) begin
                    dec_kind = DEC_CMP_HI;
                end
            end
`endif
        end
    end

endmodule

// File: rtl/apb_clint_timer.sv
// APB CLINT-style machine timer: free-running mtime, per-hart mtimecmp/msip and irq lines.
// Optional hart-local alias window is enabled with CLINT_HART_ALIAS_EN (see clint_addr_decode).
module apb_clint_timer
    import clint_pkg::*;
#(
    parameter int N_HARTS  = 2,
    parameter int W_PADDR  = 16,
    parameter int W_DATA   = 32,
    parameter int TICK_DIV = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [W_PADDR-1:0] apbs_paddr,
    input  logic               apbs_psel,
    input  logic               apbs_penable,
    input  logic               apbs_pwrite,
    input  logic [W_DATA-1:0]  apbs_pwdata,
    output logic               apbs_pready,
    output logic [W_DATA-1:0]  apbs_prdata,
    output logic               apbs_pslverr,
    input  logic [31:0]        apbs_phartid,
    output logic [N_HARTS-1:0] irq_mtip,
    output logic [N_HARTS-1:0] irq_msip
);

    localparam int                 PRESC_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

    dec_e                  dec_kind;
    logic [HART_IDX_W-1:0] dec_hart;
    logic                  dec_err;
    logic                  access;
    logic                  wr_en;
    logic                  rd_cap;
    logic                  rd_ack;
    logic                  mtime_wr;
    logic                  tick;
    logic [PRESC_W-1:0]    presc;
    logic [63:0]           mtime;
    logic [63:0]           mtimecmp [N_HARTS];
    logic [N_HARTS-1:0]    msip;
    logic [31:0]           rd_data;

    clint_addr_decode #(
        .N_HARTS (N_HARTS),
        .W_PADDR (W_PADDR)
    ) u_decode (
        .paddr    (apbs_paddr),
        .phartid  (apbs_phartid),
        .dec_kind (dec_kind),
        .dec_hart (dec_hart)
    );

    // Writes complete in a single access cycle; reads insert one wait state via rd_ack.
    assign access      = apbs_psel & apbs_penable;
    assign wr_en       = access & apbs_pwrite;
    assign rd_cap      = access & ~apbs_pwrite & ~rd_ack;
    assign apbs_pready = ~rd_cap;
    assign dec_err     = (dec_kind == DEC_ERR);
    assign mtime_wr    = wr_en & ((dec_kind == DEC_MTIME_LO) | (dec_kind == DEC_MTIME_HI));
    assign tick        = (presc == PRESC_MAX);

    // A software write to mtime restarts the tick period so the new value holds a full tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (mtime_wr || tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime <= '0;
        end else if (wr_en && dec_kind == DEC_MTIME_LO) begin
            mtime[31:0] <= apbs_pwdata;
        end else if (wr_en && dec_kind == DEC_MTIME_HI) begin
            mtime[63:32] <= apbs_pwdata;
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msip <= '0;
            for (int h = 0; h < N_HARTS; h++) begin
                mtimecmp[h] <= '1;
            end
        end else if (wr_en) begin
            for (int h = 0; h < N_HARTS; h++) begin
                if (dec_hart == HART_IDX_W'(h)) begin
                    case (dec_kind)
                        DEC_MSIP:   msip[h]               <= apbs_pwdata[0];
                        DEC_CMP_LO: mtimecmp[h][31:0]     <= apbs_pwdata;
                        DEC_CMP_HI: mtimecmp[h][63:32]    <= apbs_pwdata;
                        default:    ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_mtip <= '0;
            irq_msip <= '0;
        end else begin
            irq_msip <= msip;
            for (int h = 0; h < N_HARTS; h++) begin
                irq_mtip[h] <= (mtime >= mtimecmp[h]);
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (dec_kind)
            DEC_MTIME_LO: rd_data = mtime[31:0];
            DEC_MTIME_HI: rd_data = mtime[63:32];
            default: begin
                for (int h = 0; h < N_HARTS; h++) begin
                    if (dec_hart == HART_IDX_W'(h)) begin
                        if (dec_kind == DEC_MSIP) begin
                            rd_data = {31'h0, msip[h]};
                        end else if (dec_kind == DEC_CMP_LO) begin
                            rd_data = mtimecmp[h][31:0];
                        end else if (dec_kind == DEC_CMP_HI) begin
                            rd_data = mtimecmp[h][63:32];
                        end
                    end
                end
            end
        endcase
    end

    // pslverr reflects the most recent write or read capture and holds between accesses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            apbs_prdata  <= '0;
            apbs_pslverr <= 1'b0;
            rd_ack       <= 1'b0;
        end else begin
            rd_ack <= rd_cap;
            if (rd_cap) begin
                apbs_prdata  <= rd_data;
                apbs_pslverr <= dec_err;
            end else if (wr_en) begin
                apbs_pslverr <= dec_err;
            end
        end
    end

endmodule

// File: tb/tb_apb_clint_timer.sv
// Self-checking bench for apb_clint_timer against an address-map level reference model.
// Exercises the alias window when built with CLINT_HART_ALIAS_EN, otherwise checks it is unmapped.
module tb_apb_clint_timer;

    localparam int N_HARTS = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [15:0]        apbs_paddr;
    logic               apbs_psel;
    logic               apbs_penable;
    logic               apbs_pwrite;
    logic [31:0]        apbs_pwdata;
    logic               apbs_pready;
    logic [31:0]        apbs_prdata;
    logic               apbs_pslverr;
    logic [31:0]        apbs_phartid;
    logic [N_HARTS-1:0] irq_mtip;
    logic [N_HARTS-1:0] irq_msip;

    int checks = 0;
    int errors = 0;

    logic [63:0]        m_mtime;
    logic [63:0]        m_cmp [N_HARTS];
    logic [N_HARTS-1:0] m_msip;
    logic [N_HARTS-1:0] m_irq_mtip;
    logic [N_HARTS-1:0] m_irq_msip;

    always #5 clk = ~clk;

    apb_clint_timer #(
        .N_HARTS  (N_HARTS),
        .W_PADDR  (16),
        .W_DATA   (32),
        .TICK_DIV (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .apbs_paddr   (apbs_paddr),
        .apbs_psel    (apbs_psel),
        .apbs_penable (apbs_penable),
        .apbs_pwrite  (apbs_pwrite),
        .apbs_pwdata  (apbs_pwdata),
        .apbs_pready  (apbs_pready),
        .apbs_prdata  (apbs_prdata),
        .apbs_pslverr (apbs_pslverr),
        .apbs_phartid (apbs_phartid),
        .irq_mtip     (irq_mtip),
        .irq_msip     (irq_msip)
    );

    // Reference model: register map expressed as plain offset arithmetic.
    function automatic bit exp_err(input logic [15:0] addr, input logic [31:0] hartid);
        int a;
        a = int'(addr) & ~3;
        if (a < 4 * N_HARTS) return 1'b0;
        if (a >= 'h4000 && a < 'h4000 + 8 * N_HARTS) return 1'b0;
        if (a == 'hBFF8 || a == 'hBFFC) return 1'b0;
`ifdef CLINT_HART_ALIAS_EN
        if ((a == 'hC000 || a == 'hC008 || a == 'hC00C) && hartid < N_HARTS) return 1'b0;
`else
        if (hartid == 32'hFFFF_FFFF && a < 0) return 1'b0;
`endif
        return 1'b1;
    endfunction

    function automatic int model_hart(input logic [15:0] addr, input logic [31:0] hartid);
        int a;
        a = int'(addr) & ~3;
        if (a < 'h4000) return a / 4;
        if (a < 'hBFF8) return (a - 'h4000) / 8;
        return int'(hartid);
    endfunction

    function automatic logic [31:0] model_read(input logic [15:0] addr, input logic [31:0] hartid);
        int a;
        int h;
        if (exp_err(addr, hartid)) return 32'h0;
        a = int'(addr) & ~3;
        if (a == 'hBFF8) return m_mtime[31:0];
        if (a == 'hBFFC) return m_mtime[63:32];
        h = model_hart(addr, hartid);
        if (a < 'h4000 || a == 'hC000) return {31'h0, m_msip[h]};
        if ((a % 8) == 0) return m_cmp[h][31:0];
        return m_cmp[h][63:32];
    endfunction

    task automatic model_reset();
        m_mtime    = 64'h0;
        m_msip     = '0;
        m_irq_mtip = '0;
        m_irq_msip = '0;
        for (int h = 0; h < N_HARTS; h++) m_cmp[h] = '1;
    endtask

    // Advances one clock and applies that cycle's effect (optional write, else one tick) to the model.
    task automatic clock_edge(input bit wr, input logic [15:0] addr, input logic [31:0] data);
        logic [N_HARTS-1:0] nxt_mtip;
        logic [N_HARTS-1:0] nxt_msip;
        bit                 mt_wr;
        mt_wr = 1'b0;
        for (int h = 0; h < N_HARTS; h++) nxt_mtip[h] = (m_mtime >= m_cmp[h]);
        nxt_msip = m_msip;
        @(posedge clk);
        if (wr && !exp_err(addr, apbs_phartid)) begin
            int a;
            int h;
            a = int'(addr) & ~3;
            h = model_hart(addr, apbs_phartid);
            if (a == 'hBFF8) begin
                m_mtime[31:0] = data;
                mt_wr = 1'b1;
            end else if (a == 'hBFFC) begin
                m_mtime[63:32] = data;
                mt_wr = 1'b1;
            end else if (a < 'h4000 || a == 'hC000) begin
                m_msip[h] = data[0];
            end else if ((a % 8) == 0) begin
                m_cmp[h][31:0] = data;
            end else begin
                m_cmp[h][63:32] = data;
            end
        end
        if (!mt_wr) m_mtime = m_mtime + 64'd1;
        m_irq_mtip = nxt_mtip;
        m_irq_msip = nxt_msip;
        #1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) clock_edge(1'b0, 16'h0, 32'h0);
    endtask

    task automatic apb_write(input logic [15:0] addr, input logic [31:0] data, input bit setup,
                             output logic rdy);
        apbs_paddr  = addr;
        apbs_pwdata = data;
        apbs_pwrite = 1'b1;
        apbs_psel   = 1'b1;
        if (setup) begin
            apbs_penable = 1'b0;
            clock_edge(1'b0, 16'h0, 32'h0);
        end
        apbs_penable = 1'b1;
        #1;
        rdy = apbs_pready;
        clock_edge(1'b1, addr, data);
        apbs_psel    = 1'b0;
        apbs_penable = 1'b0;
        apbs_pwrite  = 1'b0;
    endtask

    task automatic apb_read(input logic [15:0] addr, input bit setup,
                            output logic [31:0] data, output logic err,
                            output logic [31:0] exp_data, output logic exp_e,
                            output logic rdy1, output logic rdy2);
        apbs_paddr  = addr;
        apbs_pwrite = 1'b0;
        apbs_psel   = 1'b1;
        if (setup) begin
            apbs_penable = 1'b0;
            clock_edge(1'b0, 16'h0, 32'h0);
        end
        apbs_penable = 1'b1;
        #1;
        rdy1     = apbs_pready;
        exp_data = model_read(addr, apbs_phartid);
        exp_e    = exp_err(addr, apbs_phartid);
        clock_edge(1'b0, 16'h0, 32'h0);
        rdy2 = apbs_pready;
        data = apbs_prdata;
        err  = apbs_pslverr;
        clock_edge(1'b0, 16'h0, 32'h0);
        apbs_psel    = 1'b0;
        apbs_penable = 1'b0;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        apbs_paddr   = '0;
        apbs_psel    = 1'b0;
        apbs_penable = 1'b0;
        apbs_pwrite  = 1'b0;
        apbs_pwdata  = '0;
        apbs_phartid = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (apbs_pready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_pready: got %b expected 1", apbs_pready);
        end
        checks++;
        if (apbs_prdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_prdata: got %h expected 0", apbs_prdata);
        end
        checks++;
        if (apbs_pslverr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_pslverr: got %b expected 0", apbs_pslverr);
        end
        checks++;
        if (irq_mtip !== '0 || irq_msip !== '0) begin
            errors++;
            $display("[TB] FAIL reset_irq: got mtip=%b msip=%b expected 0/0", irq_mtip, irq_msip);
        end
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_mtime_idle();
        logic [31:0] d, ed;
        logic        e, ee, r1, r2;
        idle_cycles(10);
        apb_read(16'hBFF8, 1'b1, d, e, ed, ee, r1, r2);
        checks++;
        if (d !== ed || d < 32'd11 || d > 32'd13) begin
            errors++;
            $display("[TB] FAIL idle_mtime: got %0d expected %0d (11..13)", d, ed);
        end
        checks++;
        if (r1 !== 1'b0 || r2 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL read_wait_state: got pready %b then %b expected 0 then 1", r1, r2);
        end
        checks++;
        if (e !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_pslverr: got %b expected 0", e);
        end
    endtask

    task automatic test_mtip();
        logic rdy;
        int   hit_at;
        int   rise_at;
        hit_at  = -1;
        rise_at = -1;
        apb_write(16'h4000, 32'h20, 1'b0, rdy);
        apb_write(16'h4004, 32'h0, 1'b1, rdy);
        for (int i = 0; i < 40; i++) begin
            idle_cycles(1);
            if (m_mtime == 64'h20) hit_at = i;
            if (irq_mtip[0] === 1'b1 && rise_at < 0) rise_at = i;
            checks++;
            if (irq_mtip !== m_irq_mtip) begin
                errors++;
                $display("[TB] FAIL mtip_cycle%0d: got %b expected %b", i, irq_mtip, m_irq_mtip);
            end
        end
        checks++;
        if (hit_at < 0 || rise_at !== hit_at + 1) begin
            errors++;
            $display("[TB] FAIL mtip_latency: got rise at %0d expected %0d", rise_at, hit_at + 1);
        end
        checks++;
        if (irq_mtip !== 2'b01) begin
            errors++;
            $display("[TB] FAIL mtip_final: got %b expected 01", irq_mtip);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] d, ed;
        logic        e, ee, r1, r2, rdy;
        apb_write(16'hBFF8, 32'hFFFF_FFFF, 1'b0, rdy);
        apb_write(16'hBFFC, 32'hFFFF_FFFF, 1'b0, rdy);
        for (int i = 0; i < 2; i++) begin
            idle_cycles(1);
            checks++;
            if (irq_mtip !== m_irq_mtip) begin
                errors++;
                $display("[TB] FAIL wrap_irq%0d: got %b expected %b", i, irq_mtip, m_irq_mtip);
            end
        end
        apb_read(16'hBFF8, 1'b0, d, e, ed, ee, r1, r2);
        checks++;
        if (d !== 32'd1 || d !== ed) begin
            errors++;
            $display("[TB] FAIL wrap_lo: got %h expected 00000001", d);
        end
        apb_read(16'hBFFC, 1'b0, d, e, ed, ee, r1, r2);
        checks++;
        if (d !== 32'd0 || d !== ed) begin
            errors++;
            $display("[TB] FAIL wrap_hi: got %h expected 00000000", d);
        end
        checks++;
        if (irq_mtip !== 2'b00 || irq_mtip !== m_irq_mtip) begin
            errors++;
            $display("[TB] FAIL wrap_irq_fall: got %b expected 00", irq_mtip);
        end
    endtask

    task automatic test_msip();
        logic rdy;
        apb_write(16'h0004, 32'h1, 1'b0, rdy);
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL write_pready: got %b expected 1", rdy);
        end
        checks++;
        if (irq_msip !== 2'b00) begin
            errors++;
            $display("[TB] FAIL msip_early: got %b expected 00", irq_msip);
        end
        idle_cycles(1);
        checks++;
        if (irq_msip !== 2'b10 || irq_msip !== m_irq_msip) begin
            errors++;
            $display("[TB] FAIL msip_set: got %b expected 10", irq_msip);
        end
        apb_write(16'h0004, 32'h0, 1'b1, rdy);
        idle_cycles(1);
        checks++;
        if (irq_msip !== 2'b00) begin
            errors++;
            $display("[TB] FAIL msip_clear: got %b expected 00", irq_msip);
        end
    endtask

    task automatic test_errors();
        logic [31:0] d, ed;
        logic        e, ee, r1, r2, rdy;
        apb_write(16'h0008, 32'h1, 1'b0, rdy);
        checks++;
        if (apbs_pslverr !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bad_hart_write_err: got %b expected 1", apbs_pslverr);
        end
        apb_write(16'h4010, 32'h0, 1'b0, rdy);
        checks++;
        if (apbs_pslverr !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bad_cmp_write_err: got %b expected 1", apbs_pslverr);
        end
        idle_cycles(2);
        checks++;
        if (irq_msip !== 2'b00) begin
            errors++;
            $display("[TB] FAIL bad_write_effect: got msip irq %b expected 00", irq_msip);
        end
        apb_read(16'h1234, 1'b1, d, e, ed, ee, r1, r2);
        checks++;
        if (d !== 32'h0 || e !== 1'b1) begin
            errors++;
            $display("[TB] FAIL unmapped_read: got data %h err %b expected 0 and 1", d, e);
        end
        apb_read(16'h4002, 1'b0, d, e, ed, ee, r1, r2);
        checks++;
        if (d !== ed || e !== 1'b0) begin
            errors++;
            $display("[TB] FAIL cmp_read_low_bits: got data %h err %b expected %h and 0", d, e, ed);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d, ed, v;
        logic        e, ee, r1, r2, rdy;
        for (int i = 0; i < 4; i++) begin
            v = $urandom;
            apb_write(16'h4008 + 16'(4 * (i % 2)), v, 1'b0, rdy);
            apb_read(16'h4008 + 16'(4 * (i % 2)), 1'b0, d, e, ed, ee, r1, r2);
            checks++;
            if (d !== v || d !== ed || e !== 1'b0) begin
                errors++;
                $display("[TB] FAIL b2b_%0d: got %h err %b expected %h", i, d, e, v);
            end
        end
    endtask

    function automatic logic [15:0] pick_addr(input int k);
        case (k)
            0:  return 16'h0000;
            1:  return 16'h0004;
            2:  return 16'h0008;
            3:  return 16'h4000;
            4:  return 16'h4004;
            5:  return 16'h4008;
            6:  return 16'h400C;
            7:  return 16'h4010;
            8:  return 16'hBFF8;
            9:  return 16'hBFFC;
            10: return 16'hC000;
            11: return 16'hC004;
            12: return 16'hC008;
            13: return 16'hC00C;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic test_random();
        logic [31:0] d, ed;
        logic        e, ee, r1, r2, rdy;
        for (int i = 0; i < 60; i++) begin
            logic [15:0] addr;
            logic [31:0] data;
            bit          setup;
            addr         = pick_addr($urandom_range(0, 15)) | 16'($urandom_range(0, 3));
            data         = $urandom;
            setup        = 1'($urandom_range(0, 1));
            apbs_phartid = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) begin
                apb_write(addr, data, setup, rdy);
                checks++;
                if (apbs_pslverr !== exp_err(addr, apbs_phartid) || rdy !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL rand_write%0d @%h: got err %b rdy %b expected err %b rdy 1",
                             i, addr, apbs_pslverr, rdy, exp_err(addr, apbs_phartid));
                end
            end else begin
                apb_read(addr, setup, d, e, ed, ee, r1, r2);
                checks++;
                if (d !== ed || e !== ee || r1 !== 1'b0 || r2 !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL rand_read%0d @%h: got %h err %b rdy %b%b expected %h err %b rdy 01",
                             i, addr, d, e, r1, r2, ed, ee);
                end
            end
            checks++;
            if (irq_mtip !== m_irq_mtip || irq_msip !== m_irq_msip) begin
                errors++;
                $display("[TB] FAIL rand_irq%0d: got mtip %b msip %b expected %b %b",
                         i, irq_mtip, irq_msip, m_irq_mtip, m_irq_msip);
            end
        end
        apbs_phartid = '0;
    endtask

    task automatic test_alias();
        logic [31:0] d, ed;
        logic        e, ee, r1, r2, rdy;
        apb_write(16'h0000, 32'h0, 1'b0, rdy);
        apb_write(16'h0004, 32'h0, 1'b0, rdy);
`ifdef CLINT_HART_ALIAS_EN
        apbs_phartid = 32'd1;
        apb_write(16'hC000, 32'h1, 1'b0, rdy);
        idle_cycles(1);
        checks++;
        if (irq_msip !== 2'b10) begin
            errors++;
            $display("[TB] FAIL alias_msip: got %b expected 10", irq_msip);
        end
        apbs_phartid = 32'd5;
        apb_read(16'hC008, 1'b1, d, e, ed, ee, r1, r2);
        checks++;
        if (e !== 1'b1 || d !== 32'h0) begin
            errors++;
            $display("[TB] FAIL alias_bad_hart: got err %b data %h expected 1 and 0", e, d);
        end
`else
        apbs_phartid = 32'd1;
        apb_write(16'hC000, 32'h1, 1'b0, rdy);
        checks++;
        if (apbs_pslverr !== 1'b1) begin
            errors++;
            $display("[TB] FAIL alias_off_write: got err %b expected 1", apbs_pslverr);
        end
        idle_cycles(1);
        checks++;
        if (irq_msip !== 2'b00) begin
            errors++;
            $display("[TB] FAIL alias_off_effect: got %b expected 00", irq_msip);
        end
        apb_read(16'hC008, 1'b1, d, e, ed, ee, r1, r2);
        checks++;
        if (e !== 1'b1 || d !== 32'h0) begin
            errors++;
            $display("[TB] FAIL alias_off_read: got err %b data %h expected 1 and 0", e, d);
        end
`endif
        apbs_phartid = '0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d, ed;
        logic        e, ee, r1, r2, rdy;
        apb_write(16'h0000, 32'h1, 1'b0, rdy);
        apb_write(16'h4008, 32'h0, 1'b0, rdy);
        idle_cycles(1);
        apbs_paddr   = 16'h4000;
        apbs_pwdata  = 32'h5;
        apbs_pwrite  = 1'b1;
        apbs_psel    = 1'b1;
        apbs_penable = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (irq_msip !== '0 || irq_mtip !== '0 || apbs_pslverr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset_clear: got msip %b mtip %b err %b expected 0",
                     irq_msip, irq_mtip, apbs_pslverr);
        end
        @(posedge clk);
        #1;
        apbs_psel    = 1'b0;
        apbs_penable = 1'b0;
        apbs_pwrite  = 1'b0;
        model_reset();
        rst_n = 1'b1;
        apb_read(16'h4000, 1'b0, d, e, ed, ee, r1, r2);
        checks++;
        if (d !== 32'hFFFF_FFFF || d !== ed) begin
            errors++;
            $display("[TB] FAIL mid_reset_cmp: got %h expected ffffffff", d);
        end
        apb_read(16'h0000, 1'b0, d, e, ed, ee, r1, r2);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("[TB] FAIL mid_reset_msip: got %h expected 0", d);
        end
    endtask

    initial begin
        $display("[TB] apb_clint_timer bench start");
        test_reset();
        test_mtime_idle();
        test_mtip();
        test_wrap();
        test_msip();
        test_errors();
        test_back_to_back();
        test_random();
        test_alias();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_clint_timer.md
# apb_clint_timer

APB-attached RISC-V machine timer and software-interrupt block (CLINT-style) for the multi-hart SoC. It sits directly downstream of the AHB-Lite-to-APB bridge and consumes its APB request plus the forwarded hart ID. It keeps a free-running 64-bit `mtime`, one 64-bit `mtimecmp` and one `msip` bit per hart, and drives each hart's `mtip`/`msip` interrupt lines.

## Interface
- `N_HARTS`, default 2: number of harts; legal range 1–16.
- `W_PADDR`, default 16: APB address width.
- `W_DATA`, default 32: APB data width; fixed at 32.
- `TICK_DIV`, default 1: `clk` cycles per `mtime` increment; must be ≥1.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `apbs_paddr`  in  W_PADDR  byte address; bits [1:0] ignored.
- `apbs_psel`  in  1  select.
- `apbs_penable`  in  1  access phase.
- `apbs_pwrite`  in  1  write when high.
- `apbs_pwdata`  in  32  write data.
- `apbs_pready`  out  1  access complete.
- `apbs_prdata`  out  32  registered read data.
- `apbs_pslverr`  out  1  registered error flag.
- `apbs_phartid`  in  32  requesting hart ID (used only by alias window).
- `irq_mtip`  out  N_HARTS  timer interrupt per hart, registered.
- `irq_msip`  out  N_HARTS  software interrupt per hart, registered.

## Operation
- An access is any cycle with `psel && penable`. A write acts in that cycle. The upstream bridge may present a write with `psel`, `penable` and `pwrite` all high in a single cycle and without a prior setup phase; this is accepted.
- Address map (offsets in `paddr`):
  - `0x0000 + 4*h`: `msip[h]`, bit 0 only; reads return zero in bits [31:1].
  - `0x4000 + 8*h`: `mtimecmp[h]` low word; `+4` high word.
  - `0xBFF8`: `mtime` low word; `0xBFFC`: `mtime` high word.
- Error cases:
  - Any other address sets `pslverr`.
  - Any `h >= N_HARTS` sets `pslverr`.
  - An erroring write has no effect; an erroring read returns 0.
- Prescaler: counter from 0 to `TICK_DIV-1`; `tick` pulses when it wraps. `mtime` increments by 1 on `tick`, with 64-bit wrap (all-ones → 0).
- Write to either `mtime` half:
  - The written half takes the new value.
  - The other half holds.
  - The increment is suppressed in that cycle, so the write wins over `tick`.
  - The prescaler resets to 0.
- `irq_mtip[h]` is registered as `mtime >= mtimecmp[h]`, an unsigned 64-bit compare evaluated on current register values. `irq_msip[h]` is registered from `msip[h]`.
- Reads:
  - First access cycle: `pready=0`, `prdata` and `pslverr` are captured at the clock edge, and the `rd_ack` flag is set.
  - Second cycle: `pready=1`, data valid, `rd_ack` clears.
  - `mtime` reads return live values; software handles hi/lo/hi rollover.
- `pready` = 0 only in the first read access cycle; it is 1 at all other times, including idle and writes. This lets the bridge sample `pready`/`pslverr` the cycle after a single-cycle write.
- `pslverr` is a register updated on every write access and every read capture, and held otherwise.

## Timing
- Reset values:
  - `mtime` = 0, prescaler = 0.
  - `mtimecmp[*]` = all-ones, `msip[*]` = 0.
  - `irq_mtip` = 0, `irq_msip` = 0.
  - `prdata` = 0, `pslverr` = 0, `rd_ack` = 0.
- Latency:
  - Write to `irq_*` change: 2 cycles (register update, then irq register).
  - Read: 2-cycle access (one wait state).
- Reset asserted mid-access: all state clears immediately; no partial write survives.
- With `TICK_DIV=1`, `mtime` increments every cycle not suppressed by an `mtime` write.

## Configuration
- `CLINT_HART_ALIAS_EN` defined: adds a hart-local window.
  - `0xC000`: `msip[phartid]`.
  - `0xC008` / `0xC00C`: `mtimecmp[phartid]` low/high.
  - `phartid >= N_HARTS` → `pslverr`.
- Undefined: `0xC000`–`0xC00F` decode as unmapped (`pslverr`), and `apbs_phartid` is unused.

## Structure
- Shared package `clint_pkg`: address offset constants (`MSIP_BASE`, `MTIMECMP_BASE`, `MTIME_LO`, `MTIME_HI`, `ALIAS_BASE`) and the decode result enum (`DEC_MSIP`, `DEC_CMP_LO`, `DEC_CMP_HI`, `DEC_MTIME_LO`, `DEC_MTIME_HI`, `DEC_ERR`).
- One sub-module, `clint_addr_decode`: combinational `paddr` (+`phartid`) → decode enum + hart index.

## Test plan
- Reset, `TICK_DIV=1`, idle 10 cycles → read `0xBFF8` returns 11–13, `pready` low exactly one cycle, `pslverr=0`.
- Write `0x4000`=0x20, `0x4004`=0, then wait → `irq_mtip[0]` rises 1 cycle after `mtime` reaches 0x20; `irq_mtip[1]` stays 0.
- Write `0xBFF8`=0xFFFFFFFF, `0xBFFC`=0xFFFFFFFF, wait 2 ticks → `mtime` wraps to 1; `irq_mtip` falls for every hart whose `mtimecmp` != all-ones.
- Write `0x0004`=1 → `irq_msip`=0b10 after 2 cycles; write 0 → clears.
- Write `0x0008` with `N_HARTS=2` → `pslverr=1` in the following cycle, no state change; read `0x1234` → `prdata=0`, `pslverr=1`.
- `CLINT_HART_ALIAS_EN`, `phartid`=1: write `0xC000`=1 → `irq_msip`=0b10; `phartid`=5, read `0xC008` → `pslverr=1`.
